// File: rtl/apb_master_bridge.sv
// apb_master_bridge: APB4 requester turning a valid/ready command into SETUP/ACCESS transfers, with one-cycle response strobe and wait-state watchdog
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [11:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_strb,
  input  logic [2:0]  cmd_prot,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [11:0] paddr,
  output logic [31:0] pwdata,
  output logic [3:0]  pstrb,
  output logic [2:0]  pprot,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic done, expire, accept;
  always_comb begin
    accept = state == IDLE && cmd_valid;
    done = state == ACCESS && pready;
    expire = TIMEOUT_CYCLES > 0 && state == ACCESS && !pready && cnt == CW'(TIMEOUT_CYCLES);
    state_n = state == IDLE ? (cmd_valid ? SETUP : IDLE) :
              state == SETUP ? ACCESS :
              (done || expire) ? IDLE : ACCESS;
    cmd_ready = state == IDLE;
    psel = state != IDLE;
    penable = state == ACCESS;
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      cnt <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
      rsp_timeout <= 1'b0;
      pwrite <= 1'b0;
      paddr <= '0;
      pwdata <= '0;
      pstrb <= '0;
      pprot <= '0;
    end else begin
      state <= state_n;
      rsp_valid <= done || expire;
      cnt <= accept ? '0 : (state == ACCESS && !pready && !expire) ? cnt + 1'b1 : cnt;
      if (done || expire) begin
        rsp_err <= expire || pslverr;
        rsp_timeout <= expire;
        rsp_rdata <= (expire || pwrite) ? 32'h0 : prdata;
      end
      if (accept) begin
        pwrite <= cmd_write;
        paddr <= cmd_addr;
        pwdata <= cmd_wdata;
        pstrb <= cmd_write ? cmd_strb : 4'h0;
        pprot <= cmd_prot;
      end
    end
  end
endmodule
